// File: rtl/fetcher_pkg.sv
// Shared constants and types for the fetch stage: data width, opcodes and
// compressed-quadrant codes used by predecode, plus the decoder-facing bundle.
package fetcher_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] C_Q1       = 2'b01;
    localparam logic [2:0] C_F3_JAL   = 3'b001;
    localparam logic [2:0] C_F3_J     = 3'b101;
    localparam logic [2:0] C_F3_BEQZ  = 3'b110;
    localparam logic [2:0] C_F3_BNEZ  = 3'b111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            is_c;
        logic            pred_taken;
        logic [XLEN-1:0] pred_pc;
    } fet_out_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of the icache hit word: instruction length and
// static next-PC prediction (direct jumps taken, backward branches optionally taken).
module fetch_predecode
    import fetcher_pkg::*;
#(
    parameter bit BACKWARD_TAKEN = 1'b1
) (
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            is_c_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_pc_o
);

    logic [XLEN-1:0] imm_j, imm_b, imm_cj, imm_cb, offset, fall_through;
    logic            taken;

    assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                     inst_i[30:21], 1'b0};
    assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                     inst_i[11:8], 1'b0};
    assign imm_cj = {{20{inst_i[12]}}, inst_i[12], inst_i[8], inst_i[10:9], inst_i[6],
                     inst_i[7], inst_i[2], inst_i[11], inst_i[5:3], 1'b0};
    assign imm_cb = {{23{inst_i[12]}}, inst_i[12], inst_i[6:5], inst_i[2],
                     inst_i[11:10], inst_i[4:3], 1'b0};

    assign is_c_o       = (inst_i[1:0] != 2'b11);
    assign fall_through = pc_i + (is_c_o ? 32'd2 : 32'd4);

    always_comb begin
        taken  = 1'b0;
        offset = '0;
        if (is_c_o) begin
            if (inst_i[1:0] == C_Q1) begin
                case (inst_i[15:13])
                    C_F3_J, C_F3_JAL: begin
                        taken  = 1'b1;
                        offset = imm_cj;
                    end
                    C_F3_BEQZ, C_F3_BNEZ: begin
                        taken  = BACKWARD_TAKEN && inst_i[12];
                        offset = imm_cb;
                    end
                    default: ;
                endcase
            end
        end else begin
            case (inst_i[6:0])
                OPC_JAL: begin
                    taken  = 1'b1;
                    offset = imm_j;
                end
                OPC_BRANCH: begin
                    taken  = BACKWARD_TAKEN && inst_i[31];
                    offset = imm_b;
                end
                // Indirect target unknown here; the ROB redirects on mispredict.
                OPC_JALR: taken = 1'b0;
                default:  ;
            endcase
        end
    end

    assign pred_taken_o = taken;
    assign pred_pc_o    = taken ? (pc_i + offset) : fall_through;

endmodule

// File: rtl/fetcher.sv
// Fetch stage: owns the fetch PC, issues it to the icache every cycle and
// registers one predecoded instruction per hit for the decoder.
module fetcher
    import fetcher_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
    parameter bit              BACKWARD_TAKEN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            stall,
    input  logic            icache_ready,
    input  logic [XLEN-1:0] icache_inst,
    output logic            fet_icache_enable,
    output logic [XLEN-1:0] fet_pc,
    output logic            fet_inst_valid,
    output logic [XLEN-1:0] fet_inst,
    output logic [XLEN-1:0] fet_inst_pc,
    output logic            fet_is_c,
    output logic            fet_pred_taken,
    output logic [XLEN-1:0] fet_pred_pc
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            en_q, en_d;
    fet_out_t        out_q, out_d;

    logic            pd_is_c, pd_taken;
    logic [XLEN-1:0] pd_pred_pc;

    fetch_predecode #(
        .BACKWARD_TAKEN(BACKWARD_TAKEN)
    ) u_predecode (
        .inst_i       (icache_inst),
        .pc_i         (pc_q),
        .is_c_o       (pd_is_c),
        .pred_taken_o (pd_taken),
        .pred_pc_o    (pd_pred_pc)
    );

    always_comb begin
        pc_d  = pc_q;
        en_d  = en_q;
        out_d = out_q;
        if (flush) begin
            // Fetch addresses are halfword aligned; drop bit 0 of the target.
            pc_d        = flush_pc & ~32'd1;
            en_d        = 1'b1;
            out_d.valid = 1'b0;
        end else if (!stall) begin
            if (en_q && icache_ready) begin
                out_d.valid      = 1'b1;
                out_d.inst       = icache_inst;
                out_d.pc         = pc_q;
                out_d.is_c       = pd_is_c;
                out_d.pred_taken = pd_taken;
                out_d.pred_pc    = pd_pred_pc;
                pc_d             = pd_pred_pc;
            end else begin
                out_d.valid = 1'b0;
            end
        end
    end

    // rdy low freezes everything, including reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                pc_q  <= RESET_PC;
                en_q  <= 1'b1;
                out_q <= '0;
            end else begin
                pc_q  <= pc_d;
                en_q  <= en_d;
                out_q <= out_d;
            end
        end
    end

    assign fet_icache_enable = en_q;
    assign fet_pc            = pc_q;
    assign fet_inst_valid    = out_q.valid;
    assign fet_inst          = out_q.inst;
    assign fet_inst_pc       = out_q.pc;
    assign fet_is_c          = out_q.is_c;
    assign fet_pred_taken    = out_q.pred_taken;
    assign fet_pred_pc       = out_q.pred_pc;

endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: directed scenarios from the block's intended use plus a
// randomized run against a behavioural model of fetch and static prediction.
module tb_fetcher;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, stall, icache_ready;
    logic [31:0] flush_pc, icache_inst;
    logic        fet_icache_enable, fet_inst_valid, fet_is_c, fet_pred_taken;
    logic [31:0] fet_pc, fet_inst, fet_inst_pc, fet_pred_pc;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_pc, m_inst, m_ipc, m_ppc;
    logic        m_valid, m_c, m_tk;

    fetcher #(
        .RESET_PC       (32'h0000_0000),
        .BACKWARD_TAKEN (1'b1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .stall             (stall),
        .icache_ready      (icache_ready),
        .icache_inst       (icache_inst),
        .fet_icache_enable (fet_icache_enable),
        .fet_pc            (fet_pc),
        .fet_inst_valid    (fet_inst_valid),
        .fet_inst          (fet_inst),
        .fet_inst_pc       (fet_inst_pc),
        .fet_is_c          (fet_is_c),
        .fet_pred_taken    (fet_pred_taken),
        .fet_pred_pc       (fet_pred_pc)
    );

    always #5 clk = ~clk;

    // Branch offsets assembled from their scattered bit weights.
    function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                    output logic taken, output logic [31:0] target);
        int off;
        logic c;
        off   = 0;
        taken = 1'b0;
        c     = (inst[1:0] != 2'b11);
        if (!c && inst[6:0] == 7'h6F) begin
            taken = 1'b1;
            off = (inst[31] ? -(1 << 20) : 0) + (int'(inst[19:12]) << 12)
                + (int'(inst[20]) << 11) + (int'(inst[30:21]) << 1);
        end else if (!c && inst[6:0] == 7'h63) begin
            taken = inst[31];
            off = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048
                + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        end else if (c && inst[1:0] == 2'b01 && (inst[15:13] == 3'd5 || inst[15:13] == 3'd1)) begin
            taken = 1'b1;
            off = (inst[12] ? -2048 : 0) + int'(inst[11]) * 16 + int'(inst[10:9]) * 256
                + int'(inst[8]) * 1024 + int'(inst[7]) * 64 + int'(inst[6]) * 128
                + int'(inst[5:3]) * 2 + int'(inst[2]) * 32;
        end else if (c && inst[1:0] == 2'b01 && inst[15:14] == 2'b11) begin
            taken = inst[12];
            off = (inst[12] ? -256 : 0) + int'(inst[11:10]) * 8 + int'(inst[6:5]) * 64
                + int'(inst[4:3]) * 2 + int'(inst[2]) * 32;
        end
        target = taken ? pc + 32'(off) : pc + (c ? 32'd2 : 32'd4);
    endfunction

    function automatic void model_clock();
        logic        tk;
        logic [31:0] tgt;
        if (!rdy) return;
        if (rst) begin
            m_pc = 32'h0; m_valid = 0; m_inst = 0; m_ipc = 0; m_c = 0; m_tk = 0; m_ppc = 0;
        end else if (flush) begin
            m_pc    = {flush_pc[31:1], 1'b0};
            m_valid = 0;
        end else if (!stall) begin
            if (icache_ready) begin
                predict(icache_inst, m_pc, tk, tgt);
                m_valid = 1; m_inst = icache_inst; m_ipc = m_pc;
                m_c = (icache_inst[1:0] != 2'b11); m_tk = tk; m_ppc = tgt; m_pc = tgt;
            end else begin
                m_valid = 0;
            end
        end
    endfunction

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic [31:0] fpc, input logic st,
                         input logic rd, input logic [31:0] inst);
        flush = fl; flush_pc = fpc; stall = st; icache_ready = rd; icache_inst = inst;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1;
        drive(0, 32'h0, 0, 1, 32'h0000_006F);
        tick();
        tick();
        checks++; if (fet_pc !== 32'h0) begin errors++;
            $display("FAIL reset_pc: got %h expected 00000000", fet_pc); end
        checks++; if (fet_icache_enable !== 1'b1) begin errors++;
            $display("FAIL reset_en: got %b expected 1", fet_icache_enable); end
        checks++; if ({fet_inst_valid, fet_inst, fet_inst_pc, fet_is_c, fet_pred_taken,
                       fet_pred_pc} !== '0) begin errors++;
            $display("FAIL reset_outputs: valid %b inst %h ipc %h c %b tk %b ppc %h expected all 0",
                     fet_inst_valid, fet_inst, fet_inst_pc, fet_is_c, fet_pred_taken, fet_pred_pc);
        end
        rst = 0;
    endtask

    task automatic test_addi();
        drive(0, 32'h0, 0, 1, 32'h0000_0013);
        tick();
        checks++; if ({fet_inst_valid, fet_inst_pc, fet_is_c, fet_pred_pc, fet_pc}
                      !== {1'b1, 32'h0, 1'b0, 32'h4, 32'h4}) begin errors++;
            $display("FAIL addi: valid %b ipc %h c %b ppc %h pc %h expected 1 0 0 4 4",
                     fet_inst_valid, fet_inst_pc, fet_is_c, fet_pred_pc, fet_pc);
        end
    endtask

    task automatic test_compressed();
        drive(1, 32'h10, 0, 1, 32'h0000_006F);
        tick();
        drive(0, 32'h0, 0, 1, 32'h0000_0001);
        tick();
        checks++; if ({fet_is_c, fet_pc, fet_pred_taken, fet_inst_pc}
                      !== {1'b1, 32'h12, 1'b0, 32'h10}) begin errors++;
            $display("FAIL cnop: c %b pc %h tk %b ipc %h expected 1 12 0 10",
                     fet_is_c, fet_pc, fet_pred_taken, fet_inst_pc);
        end
    endtask

    task automatic test_jal();
        drive(1, 32'h20, 0, 1, 32'h0);
        tick();
        drive(0, 32'h0, 0, 1, 32'h0080_006F);
        tick();
        checks++; if ({fet_pred_taken, fet_pc, fet_pred_pc} !== {1'b1, 32'h28, 32'h28}) begin
            errors++;
            $display("FAIL jal: tk %b pc %h ppc %h expected 1 28 28",
                     fet_pred_taken, fet_pc, fet_pred_pc);
        end
    endtask

    task automatic test_branch();
        drive(1, 32'h100, 0, 0, 32'h0);
        tick();
        drive(0, 32'h0, 0, 1, 32'hFE00_0EE3);
        tick();
        checks++; if ({fet_pred_taken, fet_pred_pc, fet_pc} !== {1'b1, 32'hFC, 32'hFC}) begin
            errors++;
            $display("FAIL beq_back: tk %b ppc %h pc %h expected 1 fc fc",
                     fet_pred_taken, fet_pred_pc, fet_pc);
        end
        drive(1, 32'h100, 0, 0, 32'h0);
        tick();
        drive(0, 32'h0, 0, 1, 32'h0000_0463);
        tick();
        checks++; if ({fet_pred_taken, fet_pred_pc, fet_pc} !== {1'b0, 32'h104, 32'h104}) begin
            errors++;
            $display("FAIL beq_fwd: tk %b ppc %h pc %h expected 0 104 104",
                     fet_pred_taken, fet_pred_pc, fet_pc);
        end
    endtask

    task automatic test_miss();
        drive(1, 32'h40, 0, 1, 32'h0);
        tick();
        drive(0, 32'h0, 0, 0, 32'h0000_0013);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({fet_pc, fet_inst_valid} !== {32'h40, 1'b0}) begin errors++;
                $display("FAIL miss[%0d]: pc %h valid %b expected 40 0", i, fet_pc, fet_inst_valid);
            end
        end
    endtask

    task automatic test_stall();
        drive(0, 32'h0, 0, 1, 32'h0000_0013);
        tick();
        drive(0, 32'h0, 1, 1, 32'h0080_006F);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({fet_pc, fet_inst_valid, fet_inst, fet_inst_pc, fet_pred_pc}
                          !== {32'h44, 1'b1, 32'h13, 32'h40, 32'h44}) begin errors++;
                $display("FAIL stall[%0d]: pc %h valid %b inst %h ipc %h ppc %h expected 44 1 13 40 44",
                         i, fet_pc, fet_inst_valid, fet_inst, fet_inst_pc, fet_pred_pc);
            end
        end
    endtask

    task automatic test_flush_stall();
        drive(1, 32'h201, 1, 1, 32'h0080_006F);
        tick();
        checks++; if ({fet_pc, fet_inst_valid, fet_icache_enable} !== {32'h200, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_stall: pc %h valid %b en %b expected 200 0 1",
                     fet_pc, fet_inst_valid, fet_icache_enable);
        end
    endtask

    task automatic test_rdy_and_reset();
        drive(1, 32'h40, 0, 0, 32'h0);
        tick();
        drive(0, 32'h0, 0, 1, 32'h0000_0013);
        tick();
        rdy = 0; rst = 1;
        drive(1, 32'h300, 0, 1, 32'h0080_006F);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({fet_pc, fet_inst_valid, fet_inst_pc, fet_inst}
                          !== {32'h44, 1'b1, 32'h40, 32'h13}) begin errors++;
                $display("FAIL rdy_freeze[%0d]: pc %h valid %b ipc %h inst %h expected 44 1 40 13",
                         i, fet_pc, fet_inst_valid, fet_inst_pc, fet_inst);
            end
        end
        rdy = 1; rst = 0;
        drive(0, 32'h0, 0, 0, 32'h0);
        tick();
        checks++; if ({fet_pc, fet_inst_valid} !== {32'h44, 1'b0}) begin errors++;
            $display("FAIL miss_after_rdy: pc %h valid %b expected 44 0", fet_pc, fet_inst_valid);
        end
        rst = 1;
        tick();
        checks++; if ({fet_pc, fet_inst_valid, fet_inst, fet_inst_pc} !== '0) begin errors++;
            $display("FAIL reset_in_miss: pc %h valid %b inst %h ipc %h expected all 0",
                     fet_pc, fet_inst_valid, fet_inst, fet_inst_pc);
        end
        rst = 0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: opc = 7'h6F;
            1, 2: opc = 7'h63;
            3: opc = 7'h67;
            default: opc = {r[6:2], 2'b11};
        endcase
        if ($urandom_range(0, 1) == 1) return {r[31:7], opc};
        if (r[25]) return {16'h0, 1'b1, r[20], r[13:2], 2'b01};
        return {16'h0, r[15:2], 2'(r[30:29] % 3)};
    endfunction

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rdy          = ($urandom_range(0, 9) != 0);
            rst          = ($urandom_range(0, 49) == 0);
            flush        = ($urandom_range(0, 19) == 0);
            flush_pc     = $urandom;
            stall        = ($urandom_range(0, 4) == 0);
            icache_ready = ($urandom_range(0, 9) < 7);
            icache_inst  = rand_inst();
            tick();
            checks++; if ({fet_pc, fet_inst_valid, fet_icache_enable} !== {m_pc, m_valid, 1'b1}) begin
                errors++;
                $display("FAIL rand_pc[%0d]: pc %h valid %b en %b expected %h %b 1",
                         i, fet_pc, fet_inst_valid, fet_icache_enable, m_pc, m_valid);
            end
            checks++; if ({fet_inst, fet_inst_pc, fet_is_c, fet_pred_taken, fet_pred_pc}
                          !== {m_inst, m_ipc, m_c, m_tk, m_ppc}) begin errors++;
                $display("FAIL rand_out[%0d]: inst %h ipc %h c %b tk %b ppc %h expected %h %h %b %b %h",
                         i, fet_inst, fet_inst_pc, fet_is_c, fet_pred_taken, fet_pred_pc,
                         m_inst, m_ipc, m_c, m_tk, m_ppc);
            end
        end
    endtask

    initial begin
        rst = 1; rdy = 1;
        drive(0, 32'h0, 0, 0, 32'h0);
        m_pc = 0; m_valid = 0; m_inst = 0; m_ipc = 0; m_c = 0; m_tk = 0; m_ppc = 0;
        test_reset();
        test_addi();
        test_compressed();
        test_jal();
        test_branch();
        test_miss();
        test_stall();
        test_flush_stall();
        test_rdy_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
